// File: rtl/online_pkg.sv
// Shared definitions for the online log-Taylor evaluator and its scheduler:
// width helpers derived from the evaluator stage count and the FSM encoding.
package online_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // Operand width of an evaluator with the given stage count
    function automatic int calc_wl(input int stage);
        return 2 * stage;
    endfunction

    // Result width: two guard bits over the operand
    function automatic int calc_rw(input int stage);
        return 2 * stage + 2;
    endfunction

    // Ceiling log2, never below 1 so that an ID field always exists
    function automatic int calc_idw(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/log_taylor_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr_i (wrapping) and grants the first
// valid requester. Produces a one-hot grant and the matching binary index.
module rr_arbiter
    import online_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    logic           found;
    logic [IDW-1:0] pos;

    // Priority scan starting at the pointer; first hit wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IDW'((int'(ptr_i) + k) % NREQ);
            if (en_i && !found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/log_taylor_scheduler.sv
// Shares one online_log_taylor evaluator among NREQ requesters. Grants at most
// one operand per cycle round-robin, drives the evaluator, and tags each
// in-flight operation so its result returns with the originating requester ID.
module log_taylor_scheduler
    import online_pkg::*;
#(
    parameter  int Stage = 8,
    parameter  int NREQ  = 4,
    parameter  int LAT   = 2,
    localparam int WL    = calc_wl(Stage),
    localparam int RW    = calc_rw(Stage),
    localparam int IDW   = calc_idw(NREQ)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               cfg_run,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*WL-1:0] req_x,
    output logic [NREQ-1:0]    req_ready,
    output logic               dp_enable,
    output logic [WL-1:0]      dp_din_x,
    input  logic [RW-1:0]      dp_dout,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [RW-1:0]      rsp_data,
    output logic               busy
);

    sched_state_e   state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_en;
    logic            accept;
    logic            any_req;
    logic            pipe_busy;
    logic [WL-1:0]   sel_x;

    // Tag pipe: one {valid, id} per cycle of evaluator latency plus the
    // capture stage, so the last stage lines up with a valid dp_dout.
    logic [LAT:0]    tag_vld_q;
    logic [IDW-1:0]  tag_id_q [0:LAT];

    logic            dp_enable_q, dp_enable_d;
    logic [WL-1:0]   dp_din_x_q, dp_din_x_d;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [RW-1:0]   rsp_data_q;

    assign any_req   = |req_valid;
    assign pipe_busy = |tag_vld_q;
    assign grant_en  = cfg_run && ((state_q == IDLE) || (state_q == RUN));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (grant_en),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    // Operand mux for the granted requester and next-state of the datapath drive
    always_comb begin
        sel_x = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*WL +: WL];
            end
        end
        dp_din_x_d = accept ? sel_x : '0;
        // Enable must stay high until the last in-flight result is captured,
        // because the evaluator clears its registers whenever it is disabled.
        dp_enable_d = accept || pipe_busy;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            if (grant_idx == IDW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // FSM next-state: grant while running, drain in-flight work when stopped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_run && any_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!cfg_run) begin
                    state_d = DRAIN;
                end else if (!any_req && !pipe_busy && !accept) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cfg_run && any_req) begin
                    state_d = RUN;
                end else if (!pipe_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Tag pipe shifts every cycle; reset discards in-flight operations
    always_ff @(posedge clk) begin
        if (!nrst) begin
            tag_vld_q <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q   <= {tag_vld_q[LAT-1:0], accept};
            tag_id_q[0] <= grant_idx;
            for (int s = 1; s <= LAT; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // Evaluator drive and tagged response capture
    always_ff @(posedge clk) begin
        if (!nrst) begin
            dp_enable_q <= 1'b0;
            dp_din_x_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            dp_enable_q <= dp_enable_d;
            dp_din_x_q  <= dp_din_x_d;
            rsp_valid_q <= tag_vld_q[LAT];
            if (tag_vld_q[LAT]) begin
                rsp_id_q   <= tag_id_q[LAT];
                rsp_data_q <= dp_dout;
            end
        end
    end

    assign dp_enable = dp_enable_q;
    assign dp_din_x  = dp_din_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);

endmodule

// File: doc/log_taylor_scheduler.md
# log_taylor_scheduler

Round-robin scheduler that shares one `online_log_taylor` evaluator (y ≈ 0.43(x−1) − 0.22(x−1)²) among NREQ requesters. Accepts at most one operand per cycle, drives the evaluator's `enable`/`din_x`, and tracks in-flight operations with a tag pipeline. Returns each result tagged with the originating requester ID. Sits between the test-platform stimulus ports and the evaluator instance.

## Interface
- `Stage`, 8: evaluator stage count; operand width WL = 2·Stage, result width WL+2.
- `NREQ`, 4: number of requesters (2..8); ID width IDW = clog2(NREQ).
- `LAT`, 2: evaluator latency in clock edges from `dp_din_x` valid to `dp_dout` valid.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset: synchronous, active-low.
- `cfg_run`  in  1  1 = grant new requests; 0 = stop granting, drain, go idle.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_x`  in  NREQ·WL  packed operands; requester i at bits [i·WL +: WL].
- `req_ready`  out  NREQ  one-hot grant (all-zero when none granted); combinational.
- `dp_enable`  out  1  evaluator enable; registered.
- `dp_din_x`  out  WL  evaluator operand; registered.
- `dp_dout`  in  WL+2  evaluator result.
- `rsp_valid`  out  1  one-cycle result strobe; registered.
- `rsp_id`  out  IDW  requester ID of the result.
- `rsp_data`  out  WL+2  captured `dp_dout`.
- `busy`  out  1  high whenever the FSM is in RUN or DRAIN.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE → RUN: `cfg_run`=1 and any `req_valid`.
  - RUN → DRAIN: `cfg_run`=0.
  - RUN → IDLE: no request, tag pipe empty, no accept this cycle.
  - DRAIN → IDLE: tag pipe empty.
  - DRAIN → RUN: `cfg_run`=1 and any `req_valid`.
- Grants occur only when `cfg_run`=1, in IDLE or RUN.
  - Scan from pointer `rr_ptr` upward, modulo NREQ.
  - The first requester with valid set is granted.
- Accept is `req_valid[i] & req_ready[i]`. On an accept:
  - `dp_din_x` ← `req_x[i]`.
  - `rr_ptr` ← (i+1) mod NREQ.
  - tag pipe stage 0 ← {1, i}.
- Without an accept, `dp_din_x` ← 0 and tag stage 0 ← {0, x}.
- The tag pipe is LAT+1 stages of {valid, id}, shifting every cycle.
  - When the last stage is valid: `rsp_valid` ← 1, `rsp_id` ← its id, `rsp_data` ← `dp_dout`.
- `dp_enable` ← 1 on any accept, or while any tag stage is valid; else 0.
  - Enable stays high until the last in-flight result is captured.
  - The evaluator zeroes its registers when enable is low, so it must never drop mid-flight.
- Responses have no backpressure; the consumer must accept every `rsp_valid` strobe.
- Reset (`nrst`=0 at an edge) clears state regardless of activity:
  - `rr_ptr` ← 0, FSM ← IDLE, all tag stages invalid.
  - In-flight operations are discarded and no `rsp_valid` is produced for them.
- Reset values of all registered outputs are 0; `busy`=0 follows from the IDLE state.

## Timing
- Accept at edge k. `dp_din_x`/`dp_enable` update at k; the evaluator captures at k+1 and its output register at k+2 (= k+LAT).
- Scheduler captures at k+LAT+1. `rsp_valid` is high in the cycle following edge k+3.
- Accept-to-response latency is LAT+1 = 3 edges.
- Throughput is 1 accept per cycle. Responses return in accept order with no gaps added.
- If `cfg_run` falls in the same cycle as a pending request, that request is not granted.
- A simultaneous accept and response in one cycle is legal and required at full rate.
- At most LAT+1 = 3 operations are in flight, bounded by the tag pipe depth.

## Structure
- Shared package (`online_pkg`) holds:
  - the WL and result-width helpers;
  - the IDW clog2 function;
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One natural sub-module is `rr_arbiter`: NREQ-wide round-robin with a pointer input, giving one-hot grant and binary index.
- Tag pipeline, FSM and enable logic stay in the top module.
- The evaluator is instantiated by the parent, not inside this block.

## Test plan
- **Single request.** Requester 2 presents x=16'h4000 while idle. Expect:
  - `req_ready`=4'b0100 in the same cycle;
  - `dp_enable`=1 and `dp_din_x`=16'h4000 after the accept edge;
  - `rsp_valid` 3 edges after accept, with `rsp_id`=2 and `rsp_data` equal to the golden evaluator model;
  - return to IDLE with `dp_enable`=0 one edge after the response.
- **All requesters continuously valid with distinct x.** Grants must rotate 0,1,2,3,0… with one accept per cycle. Responses arrive back-to-back with IDs in the same order and data matching the model.
- **Fairness.** Requesters 1 and 3 held valid with `rr_ptr`=2. Grant order must be 3,1,3,1; requester 1 is never starved.
- **Drain.** After 3 accepts, `cfg_run` is driven to 0 while requests are still valid. Expect:
  - no further `req_ready`;
  - exactly 3 responses returned;
  - `dp_enable` stays 1 until the last capture, and `busy` clears one edge later.
- **Reset mid-flight.** Assert `nrst`=0 for 1 cycle with 2 operations in flight. Expect:
  - all outputs 0 on the next edge, with no `rsp_valid` for the discarded operations;
  - the next grant goes to requester 0.
- **Gap handling.** Accepts at cycles 0, 2 and 5 must produce responses at cycles 3, 5 and 8. `dp_enable` must stay continuous through the gaps while operations are in flight.
